// File: rtl/sa_pkg.sv
// Shared constants, controller state type and output clipping for the 4x4 systolic multiplier.
// SA_SATURATE_EN selects saturating outputs; the default build wraps modulo 256.
package sa_pkg;
    localparam int N              = 4;
    localparam int DATA_W         = 8;
    localparam int ACC_W          = 18;
    localparam int COMPUTE_CYCLES = 10;
    localparam int OUT_CYCLES     = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        COMPUTE = 3'd2,
        OUT     = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic logic [DATA_W-1:0] sa_clip(input logic [ACC_W-1:0] acc);
`ifdef SA_SATURATE_EN
        return (|acc[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
        return acc[DATA_W-1:0];
`endif
    endfunction
endpackage

// File: rtl/sa_pe.sv
// Systolic MAC cell: forwards A right and B down one cycle later, accumulates a*b on its inputs.
module sa_pe
    import sa_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0]   a_q, b_q;
    logic [ACC_W-1:0]    acc_q;
    logic [2*DATA_W-1:0] prod;

    assign prod = a_i * b_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_wrapper.sv
// 4x4 output-stationary systolic multiplier C = A x B with beat-wise operand load and row-wise readout.
// Output clipping follows SA_SATURATE_EN (see sa_pkg).
//   state   | meaning
//   IDLE    | waiting for en; en captures beat 0
//   SHIFT   | capturing beats 1..3, en=0 stalls
//   COMPUTE | 10 cycles of skewed feed through the PE grid
//   OUT     | 4 cycles, one result row registered per cycle
//   DONE    | outputs 0; en restarts with cleared accumulators
module systolic_array_wrapper #(
    parameter int N      = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DATA_W-1:0] shift_in_A_0,
    input  logic [DATA_W-1:0] shift_in_A_1,
    input  logic [DATA_W-1:0] shift_in_A_2,
    input  logic [DATA_W-1:0] shift_in_A_3,
    input  logic [DATA_W-1:0] shift_in_B_0,
    input  logic [DATA_W-1:0] shift_in_B_1,
    input  logic [DATA_W-1:0] shift_in_B_2,
    input  logic [DATA_W-1:0] shift_in_B_3,
    output logic [DATA_W-1:0] shift_out_0,
    output logic [DATA_W-1:0] shift_out_1,
    output logic [DATA_W-1:0] shift_out_2,
    output logic [DATA_W-1:0] shift_out_3
);
    import sa_pkg::*;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cap, clr;
    logic [3:0]        step;
    logic [1:0]        out_row;

    logic [DATA_W-1:0] a_in [N];
    logic [DATA_W-1:0] b_in [N];
    logic [DATA_W-1:0] a_buf_q [N][N];
    logic [DATA_W-1:0] b_buf_q [N][N];
    logic [DATA_W-1:0] a_feed [N];
    logic [DATA_W-1:0] b_feed [N];
    logic [DATA_W-1:0] a_pipe [N][N+1];
    logic [DATA_W-1:0] b_pipe [N+1][N];
    logic [ACC_W-1:0]  acc [N][N];
    logic [DATA_W-1:0] out_q [N];
    logic              unused_tail;

    assign a_in[0] = shift_in_A_0;
    assign a_in[1] = shift_in_A_1;
    assign a_in[2] = shift_in_A_2;
    assign a_in[3] = shift_in_A_3;
    assign b_in[0] = shift_in_B_0;
    assign b_in[1] = shift_in_B_1;
    assign b_in[2] = shift_in_B_2;
    assign b_in[3] = shift_in_B_3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q is a down-counter of cycles remaining in the current phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    cap     = 1'b1;
                    clr     = 1'b1;
                    cnt_d   = 4'(N - 2);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    cap = 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = 4'(COMPUTE_CYCLES - 1);
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    cnt_d   = 4'(OUT_CYCLES - 1);
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Newest beat enters index 0, so after four beats index k holds element k.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf_q[i][j] <= '0;
                    b_buf_q[i][j] <= '0;
                end
            end
        end else if (cap) begin
            for (int i = 0; i < N; i++) begin
                a_buf_q[i][0] <= a_in[i];
                b_buf_q[i][0] <= b_in[i];
                for (int j = 1; j < N; j++) begin
                    a_buf_q[i][j] <= a_buf_q[i][j-1];
                    b_buf_q[i][j] <= b_buf_q[i][j-1];
                end
            end
        end
    end

    assign step = 4'(COMPUTE_CYCLES - 1) - cnt_q;

    // Row r / column r is delayed r steps; outside its 4-step window the feed is zero.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_feed[r] = '0;
            b_feed[r] = '0;
            if (state_q == COMPUTE && step >= 4'(r) && (step - 4'(r)) < 4'(N)) begin
                a_feed[r] = a_buf_q[r][2'(step - 4'(r))];
                b_feed[r] = b_buf_q[r][2'(step - 4'(r))];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        assign a_pipe[r][0] = a_feed[r];
        assign b_pipe[0][r] = b_feed[r];
        for (genvar c = 0; c < N; c++) begin : g_col
            sa_pe u_pe (
                .clk   (clk),
                .rstn  (rstn),
                .clr_i (clr),
                .a_i   (a_pipe[r][c]),
                .b_i   (b_pipe[r][c]),
                .a_o   (a_pipe[r][c+1]),
                .b_o   (b_pipe[r+1][c]),
                .acc_o (acc[r][c])
            );
        end
    end

    always_comb begin
        unused_tail = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_tail = unused_tail ^ (^a_pipe[i][N]) ^ (^b_pipe[N][i]);
        end
    end

    assign out_row = 2'(OUT_CYCLES - 1) - cnt_q[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < N; c++) out_q[c] <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                out_q[c] <= (state_q == OUT) ? sa_clip(acc[out_row][c]) : '0;
            end
        end
    end

    assign shift_out_0 = out_q[0];
    assign shift_out_1 = out_q[1];
    assign shift_out_2 = out_q[2];
    assign shift_out_3 = out_q[3];
endmodule

// File: tb/tb_systolic_array_wrapper.sv
// Self-checking bench for systolic_array_wrapper: directed matrices plus random ones against a plain matrix-product model.
module tb_systolic_array_wrapper;
    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    logic [7:0] so [4];

    int A [4][4];
    int B [4][4];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    systolic_array_wrapper #(.N(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .shift_in_A_0 (sa[0]),
        .shift_in_A_1 (sa[1]),
        .shift_in_A_2 (sa[2]),
        .shift_in_A_3 (sa[3]),
        .shift_in_B_0 (sb[0]),
        .shift_in_B_1 (sb[1]),
        .shift_in_B_2 (sb[2]),
        .shift_in_B_3 (sb[3]),
        .shift_out_0  (so[0]),
        .shift_out_1  (so[1]),
        .shift_out_2  (so[2]),
        .shift_out_3  (so[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {so[3], so[2], so[1], so[0]};
    endfunction

    // Model: plain matrix product, then wrap or saturate into 8 bits; packed col3..col0.
    function automatic logic [31:0] exp_row(input int r);
        logic [31:0] v;
        int s;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += A[r][k] * B[k][c];
`ifdef SA_SATURATE_EN
            if (s > 255) s = 255;
`else
            s = s % 256;
`endif
            v[8*c +: 8] = 8'(s);
        end
        return v;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            sa[i] = 8'($urandom_range(255));
            sb[i] = 8'($urandom_range(255));
        end
    endtask

    // Four beats; beat k carries A[r][3-k] and B[3-k][c]; optional en gap after stall_beat.
    task automatic load(input int stall_beat, input int stall_len);
        for (int k = 0; k < 4; k++) begin
            en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                sa[i] = 8'(A[i][3-k]);
                sb[i] = 8'(B[3-k][i]);
            end
            tick();
            if (k == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    en = 1'b0;
                    rand_inputs();
                    tick();
                    check("stall_zero", outs(), 32'h0);
                end
            end
        end
        en = 1'b0;
    endtask

    // After the beat-3 edge: 10 zero cycles, rows 0..3 at edges 11..14, zero again at 15.
    task automatic drain(input bit noise);
        for (int j = 1; j <= 14; j++) begin
            if (noise) begin
                en = 1'($urandom_range(1));
                rand_inputs();
            end else begin
                en = 1'b0;
            end
            tick();
            if (j <= 10) check("pre_out_zero", outs(), 32'h0);
            else         check($sformatf("row%0d", j - 11), outs(), exp_row(j - 11));
        end
        en = 1'b0;
        tick();
        check("post_out_zero", outs(), 32'h0);
    endtask

    task automatic run(input int stall_beat, input int stall_len, input bit noise);
        load(stall_beat, stall_len);
        drain(noise);
    endtask

    task automatic abort_run(input int cycles_after_load);
        load(-1, 0);
        for (int j = 0; j < cycles_after_load; j++) tick();
        rstn = 1'b0;
        #1;
        check("reset_async_zero", outs(), 32'h0);
        tick();
        check("reset_hold_zero", outs(), 32'h0);
        rstn = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            check("after_abort_zero", outs(), 32'h0);
        end
    endtask

    task automatic set_scen(input int id);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (id)
                    1: begin A[r][c] = c + 1; B[r][c] = r + 1; end
                    2: begin
                        A[r][c] = (r == 0 || r == 3 || c == 0 || c == 3) ? 1 : 0;
                        B[r][c] = 2 * (4 * r + c) + 12;
                    end
                    3: begin
                        A[r][c] = 3 * (4 * r + c);
                        B[r][c] = (r == c) ? 2 : ((r + c == 3) ? 1 : 0);
                    end
                    default: begin A[r][c] = 255; B[r][c] = 255; end
                endcase
            end
        end
    endtask

    task automatic set_rand(input int maxv);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                A[r][c] = int'($urandom_range(maxv));
                B[r][c] = int'($urandom_range(maxv));
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sa[i] = '0;
            sb[i] = '0;
        end
        tick();
        tick();
        check("reset_out", outs(), 32'h0);
        rstn = 1'b1;
        tick();
        check("idle_out", outs(), 32'h0);

        set_scen(1); run(-1, 0, 1'b0);
        set_scen(2); run(-1, 0, 1'b1);
        set_scen(3); run(-1, 0, 1'b0);
        set_scen(4); run(-1, 0, 1'b0);

        set_scen(1); abort_run(5);
        run(-1, 0, 1'b0);
        run(1, 2, 1'b0);
        abort_run(12);
        set_scen(3); run(-1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            set_rand((t % 2 == 0) ? 255 : 15);
            run((t % 3 == 0) ? int'($urandom_range(2)) : -1, int'($urandom_range(1, 3)), 1'(t % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
